// File: rtl/result_capture_fifo.sv
// Capture stage behind the vector DUT: masked compare, small result FIFO,
// vector/error counters and first-failure tracking.
module result_capture_fifo #(
   parameter int DW    = 30,
   parameter int DEPTH = 4,
   parameter int CNTW  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_result,
   input  logic [DW-1:0]   in_expect,
   input  logic [DW-1:0]   in_mask,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_result,
   output logic            out_mismatch,
   output logic [CNTW-1:0] vec_count,
   output logic [CNTW-1:0] err_count,
   output logic            first_fail_valid,
   output logic [CNTW-1:0] first_fail_idx
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]     PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   // Handshake: a transfer happens on a rising edge where valid & ready are both
   // high; valid never waits on ready, and ready depends only on registered state and clr.

   logic [DW:0]   mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          run;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          mm;
   logic [DW:0]   head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // run holds in_ready low until the first edge after reset release
   assign in_ready  = run & ~full & ~clr;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready & ~clr;
   assign mm        = |((in_result ^ in_expect) & in_mask);

   assign head         = mem[rd_ptr[AW-1:0]];
   assign out_result   = empty ? '0 : head[DW-1:0];
   assign out_mismatch = empty ? 1'b0 : head[DW];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {mm, in_result};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run              <= 1'b0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         vec_count        <= '0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else begin
         run <= 1'b1;
         if (clr) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            vec_count        <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_ONE;
               if (vec_count != CNT_MAX) begin
                  vec_count <= vec_count + CNT_ONE;
               end
               if (mm && (err_count != CNT_MAX)) begin
                  err_count <= err_count + CNT_ONE;
               end
               // index is the pre-increment count, i.e. 0-based vector number
               if (mm && !first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_idx   <= vec_count;
               end
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_result_capture_fifo.sv
// Scoreboard bench for result_capture_fifo: queued expectations checked at every pop,
// plus counter, first-fail, backpressure, clear and reset checks.
module tb_result_capture_fifo;

   localparam int DW = 30;

   logic          clk;
   logic          rst_n;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_result;
   logic [DW-1:0] in_expect;
   logic [DW-1:0] in_mask;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic          out_mismatch;
   logic [15:0]   vec_count;
   logic [15:0]   err_count;
   logic          first_fail_valid;
   logic [15:0]   first_fail_idx;

   // narrow-counter instance for saturation
   logic          clr4;
   logic          in_valid4;
   logic          in_ready4;
   logic          out_valid4;
   logic [DW-1:0] out_result4;
   logic          out_mismatch4;
   logic [3:0]    vec_count4;
   logic [3:0]    err_count4;
   logic          first_fail_valid4;
   logic [3:0]    first_fail_idx4;

   int n_checks = 0;
   int n_fail   = 0;
   int pop_cnt  = 0;
   logic [DW:0] exp_q[$];

   result_capture_fifo #(.DW(DW), .DEPTH(4), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_expect(in_expect), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_mismatch(out_mismatch),
      .vec_count(vec_count), .err_count(err_count),
      .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
   );

   result_capture_fifo #(.DW(DW), .DEPTH(4), .CNTW(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr4),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .in_result(30'h1234567), .in_expect(30'h0), .in_mask({DW{1'b1}}),
      .out_valid(out_valid4), .out_ready(1'b1),
      .out_result(out_result4), .out_mismatch(out_mismatch4),
      .vec_count(vec_count4), .err_count(err_count4),
      .first_fail_valid(first_fail_valid4), .first_fail_idx(first_fail_idx4)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: pops compared at the negative edge, away from the active edge
   always @(negedge clk) begin
      if (!rst_n || clr) begin
         exp_q.delete();
      end else if (out_valid && out_ready) begin
         pop_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_pop", {1'b0, out_mismatch, out_result}, 32'hFFFF_FFFF);
         end else begin
            check("pop_data", {1'b0, out_mismatch, out_result}, {1'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive one vector, wait (bounded) for acceptance, then queue the expected entry
   task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] e,
                       input logic [DW-1:0] m, input logic exp_mm);
      logic acc;
      acc       = 1'b0;
      in_valid  = 1'b1;
      in_result = r;
      in_expect = e;
      in_mask   = m;
      for (int g = 0; g < 60 && !acc; g++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (acc) exp_q.push_back({exp_mm, r});
      else check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || out_valid) && g < 60) begin
         tick();
         g++;
      end
      check("drain", exp_q.size(), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] r;
      int            acc4;
      int            t0;
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_result = '0; in_expect = '0; in_mask = '0;
      clr4 = 1'b0; in_valid4 = 1'b0;

      // reset state
      #12;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_vec", vec_count, 0);
      check("rst_err", err_count, 0);
      check("rst_ff", {first_fail_valid, first_fail_idx}, 0);
      rst_n = 1'b1;
      tick();
      check("ready_after_rel", in_ready, 1);

      // 1: single passing vector
      out_ready = 1'b1;
      send(30'h0000A6E8, 30'h0000A6E8, {DW{1'b1}}, 1'b0);
      check("t1_out_valid", out_valid, 1);
      check("t1_out_mm", out_mismatch, 0);
      check("t1_vec", vec_count, 1);
      check("t1_err", err_count, 0);
      wait_drain();

      // 2: bit-19 mismatch, checked then masked
      pulse_clr();
      check("t2_clr_vec", vec_count, 0);
      send(30'h0123456, 30'h0123456, {DW{1'b1}}, 1'b0);
      send(30'h0011111, 30'h0011111 ^ 30'h80000, {DW{1'b1}}, 1'b1);
      send(30'h3000000, 30'h3000000, {DW{1'b1}}, 1'b0);
      check("t2_err", err_count, 1);
      check("t2_vec", vec_count, 3);
      check("t2_ff_idx", first_fail_idx, 1);
      check("t2_ff_valid", first_fail_valid, 1);
      wait_drain();
      pulse_clr();
      send(30'h0123456, 30'h0123456, {DW{1'b1}}, 1'b0);
      send(30'h0011111, 30'h0011111 ^ 30'h80000, ~30'h80000, 1'b0);
      send(30'h3000000, 30'h3000000, {DW{1'b1}}, 1'b0);
      check("t2m_err", err_count, 0);
      check("t2m_ff_valid", first_fail_valid, 0);
      wait_drain();

      // 3: fill with backpressure, one-cycle pop releases the held 5th
      pulse_clr();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         r = DW'($urandom_range(0, 32'h3FFF_FFFF));
         send(r, r, {DW{1'b1}}, 1'b0);
      end
      check("t3_full_ready", in_ready, 0);
      fork
         send(30'h2AAAAAA, 30'h2AAAAAB, 30'h1, 1'b1);
         begin
            tick(); tick(); tick();
            check("t3_held_ready", in_ready, 0);
            check("t3_held_vec", vec_count, 4);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("t3_ready_after_pop", in_ready, 1);
         end
      join
      check("t3_vec5", vec_count, 5);
      check("t3_err5", err_count, 1);
      check("t3_ff_idx", first_fail_idx, 4);
      out_ready = 1'b1;
      wait_drain();

      // 4: full-rate push+pop, alternating mismatch
      pulse_clr();
      pop_cnt = 0;
      t0 = $time;
      for (int i = 0; i < 10; i++) begin
         r = DW'($urandom_range(0, 32'h3FFF_FFFF));
         send(r, (i % 2 == 1) ? (r ^ (30'h1 << (i * 2))) : r, {DW{1'b1}}, 1'(i % 2));
      end
      check("t4_cycles", ($time - t0) / 10, 10);
      check("t4_err", err_count, 5);
      check("t4_vec", vec_count, 10);
      check("t4_ff_idx", first_fail_idx, 1);
      wait_drain();
      check("t4_pops", pop_cnt, 10);

      // 5: CNTW=4 saturation
      clr4 = 1'b1;
      tick();
      clr4 = 1'b0;
      in_valid4 = 1'b1;
      acc4 = 0;
      for (int g = 0; g < 100 && acc4 < 20; g++) begin
         @(negedge clk);
         if (in_ready4) acc4++;
         tick();
      end
      in_valid4 = 1'b0;
      check("t5_accepts", acc4, 20);
      check("t5_vec_sat", vec_count4, 15);
      check("t5_err_sat", err_count4, 15);
      check("t5_ff_idx", first_fail_idx4, 0);
      check("t5_ff_valid", first_fail_valid4, 1);

      // 6: clr beats a simultaneous push; reset mid-burst
      pulse_clr();
      out_ready = 1'b0;
      send(30'h1111111, 30'h1111110, {DW{1'b1}}, 1'b1);
      send(30'h2222222, 30'h2222222, {DW{1'b1}}, 1'b0);
      in_valid = 1'b1;
      in_result = 30'h3333333; in_expect = 30'h0; in_mask = {DW{1'b1}};
      clr = 1'b1;
      #1;
      check("t6_clr_ready", in_ready, 0);
      tick();
      clr = 1'b0;
      in_valid = 1'b0;
      check("t6_clr_empty", out_valid, 0);
      check("t6_clr_vec", vec_count, 0);
      check("t6_clr_err", err_count, 0);
      check("t6_clr_ff", first_fail_valid, 0);
      send(30'h0ABCDEF, 30'h0ABCDEE, {DW{1'b1}}, 1'b1);
      send(30'h0FEDCBA, 30'h0FEDCBA, {DW{1'b1}}, 1'b0);
      check("t6_pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_ready", in_ready, 0);
      check("t6_rst_vec", vec_count, 0);
      check("t6_rst_ff", first_fail_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_ready_again", in_ready, 1);
      out_ready = 1'b1;
      send(30'h0000001, 30'h0000001, {DW{1'b1}}, 1'b0);
      wait_drain();
      check("t6_vec_after", vec_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
